// File: rtl/ps2_host_cmd_ctrl.sv
// ps2_host_cmd_ctrl: sends one command byte to a PS/2 keyboard over open-drain
// clock/data lines, then waits for the ACK or resend byte from the receive path.
module ps2_host_cmd_ctrl #(
    parameter int INHIBIT_CYCLES = 2700,
    parameter int EDGE_TIMEOUT   = 405000,
    parameter int ACK_TIMEOUT    = 540000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clock_27mhz,
    input  logic       reset,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    output logic       cmd_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       rx_hold,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);
    localparam int TW = $clog2((ACK_TIMEOUT > EDGE_TIMEOUT ? ACK_TIMEOUT : EDGE_TIMEOUT) + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_LINE_ACK, S_WAIT_RESP} state_t;

    state_t        r_state, w_state_n;
    logic [2:0]    r_c_sync, r_d_sync;
    logic [7:0]    r_byte, w_byte_n;
    logic          r_parity, w_parity_n;
    logic [TW-1:0] r_cnt, w_cnt_n;
    logic [3:0]    r_bit, w_bit_n;
    logic [RW-1:0] r_retry, w_retry_n;
    logic          r_c_oe, w_c_oe_n, r_d_oe, w_d_oe_n;
    logic          r_done, w_done_n, r_error, w_error_n;
    logic [1:0]    r_err_code, w_err_code_n;
    logic          w_fall, w_expired, w_frame_bit;

    assign w_fall      = r_c_sync[2] & ~r_c_sync[1];
    assign w_expired   = r_cnt == '0;
    assign w_frame_bit = r_bit < 4'd8 ? r_byte[r_bit[2:0]] : r_bit == 4'd8 ? r_parity : 1'b1;

    assign ps2c_oe   = r_c_oe;
    assign ps2d_oe   = r_d_oe;
    assign done      = r_done;
    assign error     = r_error;
    assign err_code  = r_err_code;
    assign cmd_ready = r_state == S_IDLE;
    assign rx_hold   = r_state == S_INHIBIT || r_state == S_RTS || r_state == S_SEND || r_state == S_LINE_ACK;

    always_ff @(posedge clock_27mhz) begin
        if (reset) begin
            r_c_sync   <= 3'b111;
            r_d_sync   <= 3'b111;
            r_state    <= S_IDLE;
            r_byte     <= '0;
            r_parity   <= 1'b0;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_retry    <= '0;
            r_c_oe     <= 1'b0;
            r_d_oe     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_c_sync   <= {r_c_sync[1:0], ps2c_in};
            r_d_sync   <= {r_d_sync[1:0], ps2d_in};
            r_state    <= w_state_n;
            r_byte     <= w_byte_n;
            r_parity   <= w_parity_n;
            r_cnt      <= w_cnt_n;
            r_bit      <= w_bit_n;
            r_retry    <= w_retry_n;
            r_c_oe     <= w_c_oe_n;
            r_d_oe     <= w_d_oe_n;
            r_done     <= w_done_n;
            r_error    <= w_error_n;
            r_err_code <= w_err_code_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_byte_n     = r_byte;
        w_parity_n   = r_parity;
        w_cnt_n      = w_expired ? r_cnt : r_cnt - 1'b1;
        w_bit_n      = r_bit;
        w_retry_n    = r_retry;
        w_c_oe_n     = r_c_oe;
        w_d_oe_n     = r_d_oe;
        w_done_n     = 1'b0;
        w_error_n    = 1'b0;
        w_err_code_n = r_err_code;
        case (r_state)
            S_IDLE: if (cmd_valid) begin
                w_byte_n     = cmd_byte;
                w_parity_n   = ~^cmd_byte;
                w_err_code_n = 2'b00;
                w_retry_n    = '0;
                w_cnt_n      = TW'(INHIBIT_CYCLES - 1);
                w_c_oe_n     = 1'b1;
                w_state_n    = S_INHIBIT;
            end
            S_INHIBIT: if (w_expired) begin
                w_d_oe_n  = 1'b1;
                w_state_n = S_RTS;
            end
            S_RTS: begin
                w_c_oe_n  = 1'b0;
                w_cnt_n   = TW'(EDGE_TIMEOUT - 1);
                w_bit_n   = '0;
                w_state_n = S_SEND;
            end
            S_SEND: if (w_fall) begin
                w_d_oe_n  = ~w_frame_bit;
                w_cnt_n   = TW'(EDGE_TIMEOUT - 1);
                w_bit_n   = r_bit + 1'b1;
                w_state_n = r_bit == 4'd9 ? S_LINE_ACK : S_SEND;
            end else if (w_expired) begin
                w_state_n    = S_IDLE;
                w_c_oe_n     = 1'b0;
                w_d_oe_n     = 1'b0;
                w_error_n    = 1'b1;
                w_err_code_n = 2'b01;
            end
            S_LINE_ACK: if (w_fall && !r_d_sync[2]) begin
                w_cnt_n   = TW'(ACK_TIMEOUT - 1);
                w_state_n = S_WAIT_RESP;
            end else if (w_fall || w_expired) begin
                w_state_n    = S_IDLE;
                w_c_oe_n     = 1'b0;
                w_d_oe_n     = 1'b0;
                w_error_n    = 1'b1;
                w_err_code_n = w_fall ? 2'b10 : 2'b01;
            end
            S_WAIT_RESP: if (rx_valid && rx_byte == 8'hFA) begin
                w_done_n  = 1'b1;
                w_state_n = S_IDLE;
            end else if (rx_valid && rx_byte == 8'hFE && r_retry < RW'(MAX_RETRY)) begin
                w_retry_n = r_retry + 1'b1;
                w_cnt_n   = TW'(INHIBIT_CYCLES - 1);
                w_c_oe_n  = 1'b1;
                w_state_n = S_INHIBIT;
            end else if (rx_valid || w_expired) begin
                // rx_valid takes priority over a timeout landing in the same cycle
                w_state_n    = S_IDLE;
                w_error_n    = 1'b1;
                w_err_code_n = rx_valid ? 2'b11 : 2'b10;
            end
            default: w_state_n = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_host_cmd_ctrl.sv
// tb_ps2_host_cmd_ctrl: device-side PS/2 model driving the command sequencer,
// with per-fall expected data-line values held in a queue.
module tb_ps2_host_cmd_ctrl;
    localparam int INH = 100;
    localparam int ETO = 400;
    localparam int ATO = 600;

    logic       clock_27mhz = 1'b0;
    logic       reset = 1'b1;
    logic       dev_c = 1'b1, dev_d = 1'b1;
    logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [7:0] cmd_byte = 8'h00, rx_byte = 8'h00;
    logic       rx_valid = 1'b0, rx_hold, done, error;
    logic [1:0] err_code;

    int n_vec = 0, n_bad = 0, n_done = 0, n_err = 0, n_both = 0;
    logic exp_q[$];

    typedef struct {
        logic [7:0] cmd;
        logic       ack;
        logic [7:0] rsp;
        int         done_d;
        int         err_d;
        logic [1:0] code;
    } vec_t;
    vec_t vt[6];

    assign ps2c_in = dev_c & ~ps2c_oe;
    assign ps2d_in = dev_d & ~ps2d_oe;

    ps2_host_cmd_ctrl #(
        .INHIBIT_CYCLES(INH), .EDGE_TIMEOUT(ETO), .ACK_TIMEOUT(ATO), .MAX_RETRY(3)
    ) dut (
        .clock_27mhz(clock_27mhz), .reset(reset), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
        .cmd_ready(cmd_ready), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_hold(rx_hold),
        .done(done), .error(error), .err_code(err_code)
    );

    always #5 clock_27mhz = ~clock_27mhz;

    always @(negedge clock_27mhz) begin
        if (done) n_done++;
        if (error) n_err++;
        if (done && error) n_both++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock_27mhz);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_cmd(input logic [7:0] b);
        int t = 0;
        while (!cmd_ready && t < 50) begin tick(); t++; end
        chk("cmd_ready_wait", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_byte  = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(~b[i]);
        exp_q.push_back(^b);
        exp_q.push_back(1'b0);
    endtask

    task automatic wait_send();
        int t = 0;
        while (!(!ps2c_oe && ps2d_oe && rx_hold) && t < INH + 100) begin tick(); t++; end
        chk("send_start", int'(t < INH + 100), 1);
    endtask

    task automatic dev_fall();
        logic e;
        dev_c = 1'b0;
        ticks(8);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("oe_bit", int'(ps2d_oe), int'(e));
        end
        dev_c = 1'b1;
        ticks(8);
    endtask

    task automatic frame(input logic [7:0] b, input logic ack);
        push_frame(b);
        wait_send();
        ticks(4);
        repeat (10) dev_fall();
        chk("hold_pre_ack", int'(rx_hold), 1);
        dev_d = ack;
        ticks(4);
        dev_c = 1'b0;
        ticks(8);
        dev_c = 1'b1;
        dev_d = 1'b1;
        ticks(8);
        chk("hold_post_ack", int'(rx_hold), 0);
    endtask

    initial begin
        int d0, e0, t, d_at, hold_bad;
        vt[0] = '{8'hED, 1'b0, 8'hFA, 1, 0, 2'b00};
        vt[1] = '{8'hFF, 1'b0, 8'h55, 0, 1, 2'b11};
        vt[2] = '{8'hF4, 1'b0, 8'hFA, 1, 0, 2'b00};
        vt[3] = '{8'h80, 1'b1, 8'h00, 0, 1, 2'b10};
        vt[4] = '{8'h00, 1'b0, 8'hFA, 1, 0, 2'b00};
        vt[5] = '{8'hA5, 1'b0, 8'hAA, 0, 1, 2'b11};

        ticks(3);
        chk("rst_c_oe", int'(ps2c_oe), 0);
        chk("rst_d_oe", int'(ps2d_oe), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_hold", int'(rx_hold), 0);
        chk("rst_done_err", int'({done, error}), 0);
        chk("rst_code", int'(err_code), 0);
        reset = 1'b0;
        ticks(10);

        for (int v = 0; v < 6; v++) begin
            d0 = n_done;
            e0 = n_err;
            send_cmd(vt[v].cmd);
            frame(vt[v].cmd, vt[v].ack);
            if (!vt[v].ack) send_rx(vt[v].rsp);
            ticks(3);
            chk("vec_done", n_done - d0, vt[v].done_d);
            chk("vec_err", n_err - e0, vt[v].err_d);
            chk("vec_code", int'(err_code), int'(vt[v].code));
            chk("vec_lines", int'({ps2c_oe, ps2d_oe}), 0);
            chk("vec_ready", int'(cmd_ready), 1);
        end

        // inhibit/RTS timing, plus a stray command and rx byte while busy
        d0 = n_done;
        cmd_valid = 1'b1;
        cmd_byte  = 8'hFF;
        tick();
        cmd_valid = 1'b0;
        t = 0; d_at = 0; hold_bad = 0;
        while (ps2c_oe && t < INH + 10) begin
            t++;
            if (ps2d_oe && d_at == 0) d_at = t;
            if (!rx_hold) hold_bad++;
            if (t == 5) begin cmd_valid = 1'b1; cmd_byte = 8'h11; end
            if (t == 6) cmd_valid = 1'b0;
            if (t == 10) rx_valid = 1'b1;
            if (t == 11) rx_valid = 1'b0;
            if (t == 10) rx_byte = 8'hFA;
            tick();
        end
        chk("inhibit_len", t, INH + 1);
        chk("rts_cycle", d_at, INH + 1);
        chk("inhibit_hold", hold_bad, 0);
        frame(8'hFF, 1'b0);
        chk("early_rx_ignored", n_done - d0, 0);
        send_rx(8'hFA);
        ticks(3);
        chk("inhibit_done", n_done - d0, 1);
        ticks(20);
        chk("no_queued_cmd", int'(ps2c_oe), 0);

        // three resends then ACK
        d0 = n_done; e0 = n_err;
        send_cmd(8'hED);
        repeat (3) begin frame(8'hED, 1'b0); send_rx(8'hFE); end
        frame(8'hED, 1'b0);
        send_rx(8'hFA);
        ticks(3);
        chk("resend_done", n_done - d0, 1);
        chk("resend_err", n_err - e0, 0);

        // four resends exhaust retries
        d0 = n_done; e0 = n_err;
        send_cmd(8'h55);
        repeat (4) begin frame(8'h55, 1'b0); send_rx(8'hFE); end
        ticks(3);
        chk("retry_err", n_err - e0, 1);
        chk("retry_code", int'(err_code), 3);
        chk("retry_done", n_done - d0, 0);

        // device stops clocking on the fifth fall
        send_cmd(8'h3C);
        push_frame(8'h3C);
        wait_send();
        ticks(4);
        repeat (4) dev_fall();
        dev_c = 1'b0;
        t = 0;
        while (!error && t < ETO + 50) begin tick(); t++; end
        chk("edge_to_cycles", t, ETO + 3);
        chk("edge_to_code", int'(err_code), 1);
        chk("edge_to_lines", int'({ps2c_oe, ps2d_oe}), 0);
        dev_c = 1'b1;
        exp_q.delete();
        ticks(10);

        // no response byte after a good line-ack
        e0 = n_err;
        send_cmd(8'hF0);
        frame(8'hF0, 1'b0);
        t = 0;
        while (n_err == e0 && t < ATO + 20) begin tick(); t++; end
        chk("ack_to_err", n_err - e0, 1);
        chk("ack_to_code", int'(err_code), 2);

        // reset during bit 4 of the frame
        send_cmd(8'hE5);
        push_frame(8'hE5);
        wait_send();
        ticks(4);
        repeat (4) dev_fall();
        dev_c = 1'b0;
        ticks(4);
        chk("pre_rst_d_oe", int'(ps2d_oe), 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_lines", int'({ps2c_oe, ps2d_oe}), 0);
        chk("mid_rst_ready", int'(cmd_ready), 1);
        reset = 1'b0;
        dev_c = 1'b1;
        exp_q.delete();
        ticks(10);
        d0 = n_done;
        send_cmd(8'hF4);
        frame(8'hF4, 1'b0);
        send_rx(8'hFA);
        ticks(3);
        chk("post_rst_done", n_done - d0, 1);
        chk("post_rst_code", int'(err_code), 0);

        chk("done_error_overlap", n_both, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_host_cmd_ctrl.md
Name: ps2_host_cmd_ctrl

Overview:
Host-to-device command sequencer for the PS/2 keyboard port. It accepts one command byte at a time (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) and drives the open-drain PS/2 clock/data lines through the inhibit, request-to-send, bit-shift and line-ack phases. It then waits for the keyboard's response byte from the existing receive path: 0xFA means success, 0xFE triggers a resend. It sits beside the receive decoder and arbitrates line ownership between transmit and receive.

Parameters:
INHIBIT_CYCLES, 2700, clock_27mhz cycles the host holds ps2c low before request-to-send (100 us)
EDGE_TIMEOUT, 405000, max cycles waiting for any device clock falling edge during transmit (15 ms)
ACK_TIMEOUT, 540000, max cycles from line-ack to response byte (20 ms)
MAX_RETRY, 3, resends allowed on 0xFE before error

Ports:
clock_27mhz  in  1  system clock; all logic rises on it
reset  in  1  synchronous, active-high
ps2c_in  in  1  raw PS/2 clock pin level (asynchronous)
ps2d_in  in  1  raw PS/2 data pin level (asynchronous)
ps2c_oe  out  1  1 = pull PS/2 clock low
ps2d_oe  out  1  1 = pull PS/2 data low
cmd_valid  in  1  command request
cmd_byte  in  8  command byte, sampled when cmd_valid & cmd_ready
cmd_ready  out  1  high only in IDLE
rx_valid  in  1  one-cycle strobe: byte from receive path
rx_byte  in  8  received byte
rx_hold  out  1  receive path must discard frames while high
done  out  1  one-cycle pulse: 0xFA received
error  out  1  one-cycle pulse: command failed
err_code  out  2  01 edge timeout, 10 no line-ack/ack timeout, 11 retries exhausted or unexpected byte; holds until next accepted command

Behaviour:
- Reset is synchronous, active-high; clock is clock_27mhz. After reset: state IDLE; ps2c_oe=0, ps2d_oe=0, cmd_ready=1, rx_hold=0, done=0, error=0, err_code=00, retry count 0. Reset asserted mid-transfer releases both lines on the next edge.
- ps2c_in and ps2d_in each pass through 3-flop synchronizers. fall = sync[2] & ~sync[1].
- IDLE: on cmd_valid, latch the byte and compute parity = ~^byte (odd parity). Clear err_code and retry count; go to INHIBIT.
- INHIBIT: ps2c_oe=1 for exactly INHIBIT_CYCLES cycles, then RTS.
- RTS: exactly 1 cycle with ps2c_oe=1 and ps2d_oe=1 (start bit). Then SEND with ps2c_oe=0 and ps2d_oe held 1.
- SEND: bit index k=0..9. On each fall, drive frame bit k: data[0..7] LSB first, k=8 parity, k=9 stop (ps2d_oe=0). ps2d_oe = ~bit. Then increment k. After the stop bit, go to LINE_ACK.
- LINE_ACK: on the next fall, sample synced data. 0 → WAIT_RESP; 1 → error, err_code=10.
- Timeout counter reloads on entry to SEND and on every fall. Expiry in SEND or LINE_ACK → error, err_code=01.
- WAIT_RESP: ACK_TIMEOUT counter runs.
  - rx_valid with 0xFA → done pulse, return to IDLE.
  - rx_valid with 0xFE: if retries < MAX_RETRY, increment retries and go to INHIBIT with the same byte; else error, 11.
  - Any other byte → error, 11.
  - Timeout → error, 10.
- rx_hold=1 in INHIBIT, RTS, SEND and LINE_ACK; 0 otherwise. rx_valid outside WAIT_RESP is ignored.
- On error: both oe deasserted the same cycle, error pulses 1 cycle, return to IDLE.
- done and error are never high together. cmd_valid while not IDLE is ignored; no queueing.
- rx_valid and timeout expiring in the same cycle: rx_valid wins.

Test Plan:
- cmd 0xED, device model clocks 11 falls, line-ack 0, then rx 0xFA → ps2d_oe per fall = 0,1,0,0,1,0,0,0 (data), parity oe 0, stop oe 0. done pulses once; err_code=00.
- INHIBIT timing: cmd 0xFF → ps2c_oe high exactly 2701 cycles (2700 + 1 RTS cycle). ps2d_oe rises on cycle 2701. rx_hold high from cycle 1 through the line-ack fall.
- Resend: rx 0xFE three times, then 0xFA → 4 full frames sent, done on the last; rx 0xFE four times → error, err_code=11.
- Device stops clocking after 5 falls → error exactly 405000 cycles after the 5th fall, err_code=01, both oe=0.
- Line-ack data=1 → error, err_code=10; no ACK byte within 540000 cycles → error, 10.
- Reset asserted during SEND bit 4 → next cycle ps2c_oe=ps2d_oe=0, cmd_ready=1; a new cmd 0xF4 then completes normally.
